// File: rtl/cv32e40p_pkg.sv
// Shared fetch-path constants so the prefetcher and the fetch FIFO agree on depth.
package cv32e40p_pkg;

  localparam int unsigned FETCH_FIFO_DEPTH_MIN = 32'd2;
  localparam int unsigned FETCH_FIFO_DEPTH_MAX = 32'd8;
  localparam int unsigned FETCH_FIFO_DEPTH     = 32'd2;

endpackage

// File: rtl/cv32e40p_fetch_fifo.sv
// Instruction prefetch FIFO: buffers OBI fetch responses for the aligner,
// with zero-latency fall-through when empty and flush on taken branches.
module cv32e40p_fetch_fifo
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH     = FETCH_FIFO_DEPTH,
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 32'd1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [31:0]          push_rdata_i,
  output logic                 fetch_valid_o,
  output logic [31:0]          fetch_rdata_o,
  input  logic                 fetch_ready_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 almost_full_o,
  output logic                 overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [31:0]          mem_r [DEPTH];
  logic [PTR_W-1:0]     rptr_r;
  logic [PTR_W-1:0]     wptr_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 overflow_r;

  logic                 empty_s;
  logic                 full_s;
  logic                 pop_s;
  logic                 bypass_s;
  logic                 write_s;
  logic                 drop_s;

  // Explicit compare keeps the wrap correct for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 32'd1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = ptr + PTR_W'(1);
    end
  endfunction

  // Status decode and handshake qualification from registered state.
  always_comb begin
    empty_s  = (cnt_r == CNT_WIDTH'(0));
    full_s   = (cnt_r == CNT_WIDTH'(DEPTH));
    fetch_valid_o = !flush_i && (!empty_s || push_i);
    pop_s    = fetch_valid_o && fetch_ready_i;
    bypass_s = empty_s && push_i && pop_s;
    write_s  = push_i && !flush_i && !bypass_s && (!full_s || pop_s);
    drop_s   = push_i && !flush_i && full_s && !pop_s;
  end

  // Head word selection: stored head, fall-through word, or zero when idle.
  always_comb begin
    fetch_rdata_o = 32'h0000_0000;
    if (!empty_s) begin
      fetch_rdata_o = mem_r[rptr_r];
    end else if (push_i) begin
      fetch_rdata_o = push_rdata_i;
    end else begin
      fetch_rdata_o = 32'h0000_0000;
    end
  end

  // Pointer, count and sticky overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_r     <= '0;
      wptr_r     <= '0;
      cnt_r      <= '0;
      overflow_r <= 1'b0;
    end else if (flush_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (write_s) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (pop_s && !bypass_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      if (write_s && !(pop_s && !bypass_s)) begin
        cnt_r <= cnt_r + CNT_WIDTH'(1);
      end else if (!write_s && pop_s && !bypass_s) begin
        cnt_r <= cnt_r - CNT_WIDTH'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[wptr_r] <= push_rdata_i;
    end
  end

  assign cnt_o         = cnt_r;
  assign empty_o       = empty_s;
  assign full_o        = full_s;
  assign almost_full_o = (cnt_r >= CNT_WIDTH'(DEPTH - 32'd1));
  assign overflow_o    = overflow_r;

`ifdef CV32E40P_ASSERT_ON
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && full_s && !pop_s));
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_r <= CNT_WIDTH'(DEPTH));
  a_rdata_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (fetch_valid_o && !fetch_ready_i && !flush_i) |=> $stable(fetch_rdata_o));
`endif

endmodule
